mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Parametrised multi-cycle load/store unit. It replaces the fixed RAM + MDR data path between the CU/ALU and the data memory.
//   Accepts one request at a time over a valid/ready handshake and drives a synchronous word-wide memory with byte strobes.
//   Memory read latency is configurable. Loads return byte/half/word data, sign- or zero-extended.
//   Misaligned, reserved-size and out-of-range accesses are flagged, and no memory access is made for them.
// PARAMETERS
//   ADDR_W       8   byte-address width of data memory; mem_addr is ADDR_W-2 bits
//   WAIT_CYCLES  1   cycles from mem_en to valid mem_rdata (>=1; 1 = standard sync RAM)
//   CHECK_RANGE  1   1: any req_addr bit above ADDR_W-1 set -> error; 0: upper bits ignored
// PORTS
//   clk          in   1         clock; all state updates on rising edge
//   rst_         in   1         asynchronous reset, active low
//   req_valid    in   1         request present
//   req_ready    out  1         unit can accept (high only in IDLE)
//   req_we       in   1         1 store, 0 load
//   req_size     in   2         0 byte, 1 half, 2 word, 3 reserved
//   req_se       in   1         loads: 1 sign-extend, 0 zero-extend
//   req_addr     in   32        byte address (ALU result)
//   req_wdata    in   32        store data, right-aligned
//   resp_valid   out  1         one-cycle pulse: request finished
//   resp_err     out  1         qualifies resp_valid: request rejected
//   resp_rdata   out  32        load result; 0 for stores and errors
//   mem_en       out  1         memory access strobe
//   mem_we       out  1         write enable (only with mem_en)
//   mem_wstrb    out  4         byte-lane write strobes, bit i = byte lane i
//   mem_addr     out  ADDR_W-2  word address = req_addr[ADDR_W-1:2]
//   mem_wdata    out  32        store data shifted into the strobed lane(s)
//   mem_rdata    in   32        synchronous read data
// BEHAVIOUR
//   Reset: state IDLE, wait counter 0, all request latches 0.
//     Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
//   Handshake: accept on the rising edge (cycle T) where req_valid && req_ready.
//     All req_* fields are latched at T; they are don't-care afterwards.
//     No backpressure on the response: resp_valid is a one-cycle pulse.
//   Error check at accept; any of the following is an error:
//     size 3; size 1 with addr[0]=1; size 2 with addr[1:0]!=0; CHECK_RANGE=1 and addr[31:ADDR_W]!=0.
//   FSM states: IDLE, ACCESS, WAIT, RESP, ERR.
//     IDLE  -> ERR on accept with error; -> ACCESS on accept otherwise.
//     ERR   (cycle T+1): resp_valid=1, resp_err=1, resp_rdata=0; mem_en never asserted. -> IDLE.
//     ACCESS (T+1): mem_en=1; mem_we=req_we; mem_addr, mem_wstrb and mem_wdata driven from the latches.
//       Store: memory commits at end of T+1 -> RESP.
//       Load: mem_we=0, mem_wstrb=0 -> WAIT, counter loaded with WAIT_CYCLES-1.
//     WAIT: mem_en=0; counter decrements each cycle.
//       When counter==0, mem_rdata is captured and extracted at the end of that cycle -> RESP.
//     RESP: resp_valid=1, resp_err=0; resp_rdata = extracted load value, or 0 for a store. -> IDLE.
//   Latency from accept edge T:
//     store: resp in T+2; load: resp in T+2+WAIT_CYCLES; error: resp in T+1.
//     Throughput: next accept no earlier than the edge ending the resp cycle.
//   Store lanes (a = addr[1:0]):
//     byte: wstrb = 1<<a, wdata = {4{wdata[7:0]}}.
//     half: wstrb = 3<<a, wdata = {2{wdata[15:0]}}.
//     word: wstrb = 4'hF, wdata unchanged.
//   Load extract: byte = rdata[8a+7:8a]; half = rdata[8a+15:8a]; extend to 32 bits per the latched req_se.
//   All outputs come from registered state and latches; there is no combinational path from req_* or mem_rdata to outputs.
//   Reset mid-operation: immediate return to IDLE.
//     The pending response is discarded and never emitted.
//     A store whose ACCESS cycle is cut by reset before the edge is not performed, because mem_en drops asynchronously.
// TESTING
//   Store byte: addr 0x13, wdata 0x0000_00A5 -> T+1: mem_en=1, mem_we=1, addr 0x04, wstrb 4'b1000, wdata 0xA5A5_A5A5; resp T+2, err=0.
//   Signed half load: mem word 0x8001_1234 at word 0x04, addr 0x12, se=1 -> resp T+3, rdata 0xFFFF_8001; with se=0 -> 0x0000_8001.
//   Misaligned word load at 0x06 -> T+1 resp_valid=1, resp_err=1, rdata 0; mem_en=0 throughout. Repeat with size 3.
//   WAIT_CYCLES=3: byte load at 0x01 of 0x0000_F700, se=1 -> resp at T+5, rdata 0xFFFF_FFF7; req_ready low T+1..T+5.
//     Back-to-back store then load to the same address reads the new data.
//   CHECK_RANGE=1, ADDR_W=8, addr 0x100 -> error; CHECK_RANGE=0 -> accesses word 0x00.
//   rst_ low during WAIT -> outputs at reset values immediately; no resp_valid after release; req_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store unit driving a word-wide sync RAM with byte strobes
module mem_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int CHECK_RANGE = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic we_q, se_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, shifted, ext;
  logic accept, bad;
  assign accept = req_valid && state == IDLE;
  assign bad = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
               (CHECK_RANGE != 0 && (req_addr >> ADDR_W) != 32'd0);
  assign strb_d = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                  req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
  assign wdata_d = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                   req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ext = size_q == 2'd0 ? {{24{se_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'd1 ? {{16{se_q & shifted[15]}}, shifted[15:0]} : mem_rdata;
  // state register; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else state <= next;
  end
  // next-state decode
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? (bad ? ERR : ACCESS) : IDLE;
      ACCESS:  next = we_q ? RESP : WAIT;
      WAIT:    next = cnt == '0 ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end
  // request latches, wait counter and captured load result
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        se_q    <= req_se;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W-1:0];
        strb_q  <= strb_d;
        wdata_q <= wdata_d;
      end
      if (state == ACCESS) cnt <= CW'(WAIT_CYCLES - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) rdata_q <= ext;
    end
  end
  // outputs decoded from registered state and latches only
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == RESP || state == ERR;
    resp_err   = state == ERR;
    resp_rdata = state == RESP && !we_q ? rdata_q : 32'd0;
    mem_en     = state == ACCESS;
    mem_we     = state == ACCESS && we_q;
    mem_wstrb  = state == ACCESS && we_q ? strb_q : 4'd0;
    mem_addr   = state == ACCESS ? addr_q[ADDR_W-1:2] : '0;
    mem_wdata  = state == ACCESS && we_q ? wdata_q : 32'd0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of two unit configurations sharing one request stream
module tb_mem_access_unit;
  logic clk = 1'b0, rst_ = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_se = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic rdy[2], rv[2], re[2], en[2], we[2];
  logic [31:0] rdat[2], wd[2];
  logic [3:0] strb[2];
  logic [5:0] maddr[2];
  logic [31:0] mem[2][64];
  logic [31:0] p0[2], p1, p2;
  logic acc_we;
  logic [5:0] acc_addr;
  logic [3:0] acc_strb;
  logic [31:0] acc_wdata;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(1), .CHECK_RANGE(1)) u0 (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_err(re[0]), .resp_rdata(rdat[0]), .mem_en(en[0]), .mem_we(we[0]),
    .mem_wstrb(strb[0]), .mem_addr(maddr[0]), .mem_wdata(wd[0]), .mem_rdata(p0[0]));

  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(3), .CHECK_RANGE(0)) u1 (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_err(re[1]), .resp_rdata(rdat[1]), .mem_en(en[1]), .mem_we(we[1]),
    .mem_wstrb(strb[1]), .mem_addr(maddr[1]), .mem_wdata(wd[1]), .mem_rdata(p2));

  // byte-strobed RAMs; u1's read data passes through two extra stages for a 3-cycle latency
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d] && we[d])
        for (int i = 0; i < 4; i++)
          if (strb[d][i]) mem[d][maddr[d]][8*i +: 8] <= wd[d][8*i +: 8];
      if (en[d] && !we[d]) p0[d] <= mem[d][maddr[d]];
    end
    p1 <= p0[1];
    p2 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic se,
                     input logic [31:0] a, input logic [31:0] wdat,
                     input int l0, input logic e0, input logic [31:0] r0,
                     input int l1, input logic e1, input logic [31:0] r1);
    int lat[2];
    int ens[2];
    logic erq[2];
    logic [31:0] rdq[2];
    int busy;
    lat = '{0, 0};
    ens = '{0, 0};
    erq = '{1'b0, 1'b0};
    rdq = '{32'd0, 32'd0};
    busy = 0;
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, rdy[0], rdy[1]}, 32'd3);
    req_we = w; req_size = sz; req_se = se; req_addr = a; req_wdata = wdat; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rv[d] && lat[d] == 0) begin
          lat[d] = k;
          erq[d] = re[d];
          rdq[d] = rdat[d];
        end
        if (en[d]) ens[d]++;
      end
      if (!rdy[1]) busy++;
      if (en[0]) begin
        acc_we = we[0];
        acc_addr = maddr[0];
        acc_strb = strb[0];
        acc_wdata = wd[0];
      end
    end
    check({tag, "_lat0"}, lat[0], l0);
    check({tag, "_err0"}, {31'd0, erq[0]}, {31'd0, e0});
    check({tag, "_rdata0"}, rdq[0], r0);
    check({tag, "_en0"}, ens[0], e0 ? 0 : 1);
    check({tag, "_lat1"}, lat[1], l1);
    check({tag, "_err1"}, {31'd0, erq[1]}, {31'd0, e1});
    check({tag, "_rdata1"}, rdq[1], r1);
    check({tag, "_en1"}, ens[1], e1 ? 0 : 1);
    check({tag, "_busy1"}, busy, l1);
  endtask

  initial begin
    int hits;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ctl", {26'd0, rdy[d], rv[d], re[d], en[d], we[d], 1'b0}, 32'h20);
      check("rst_bus", {22'd0, strb[d], maddr[d]}, 32'd0);
      check("rst_data", rdat[d] | wd[d], 32'd0);
    end
    rst_ = 1'b1;
    txn("sw10", 1, 2, 0, 32'h10, 32'h8001_1234, 2, 0, 0, 2, 0, 0);
    check("sw10_strb", acc_strb, 4'hF);
    txn("lh12s", 0, 1, 1, 32'h12, 0, 3, 0, 32'hFFFF_8001, 5, 0, 32'hFFFF_8001);
    txn("lh12z", 0, 1, 0, 32'h12, 0, 3, 0, 32'h0000_8001, 5, 0, 32'h0000_8001);
    txn("sb13", 1, 0, 0, 32'h13, 32'h0000_00A5, 2, 0, 0, 2, 0, 0);
    check("sb13_acc", {acc_we, acc_strb, acc_addr}, {1'b1, 4'b1000, 6'h04});
    check("sb13_wdata", acc_wdata, 32'hA5A5_A5A5);
    txn("lb13s", 0, 0, 1, 32'h13, 0, 3, 0, 32'hFFFF_FFA5, 5, 0, 32'hFFFF_FFA5);
    txn("lh10s", 0, 1, 1, 32'h10, 0, 3, 0, 32'h0000_1234, 5, 0, 32'h0000_1234);
    txn("sw00", 1, 2, 0, 32'h00, 32'h0000_F700, 2, 0, 0, 2, 0, 0);
    txn("lb01s", 0, 0, 1, 32'h01, 0, 3, 0, 32'hFFFF_FFF7, 5, 0, 32'hFFFF_FFF7);
    txn("lb01z", 0, 0, 0, 32'h01, 0, 3, 0, 32'h0000_00F7, 5, 0, 32'h0000_00F7);
    txn("lw06", 0, 2, 0, 32'h06, 0, 1, 1, 0, 1, 1, 0);
    txn("sz3", 0, 3, 0, 32'h00, 0, 1, 1, 0, 1, 1, 0);
    txn("lh11", 0, 1, 1, 32'h11, 0, 1, 1, 0, 1, 1, 0);
    txn("lw100", 0, 2, 0, 32'h100, 0, 1, 1, 0, 5, 0, 32'h0000_F700);
    txn("sh12", 1, 1, 0, 32'h12, 32'h1234_BEEF, 2, 0, 0, 2, 0, 0);
    check("sh12_acc", {acc_we, acc_strb, acc_addr}, {1'b1, 4'b1100, 6'h04});
    check("sh12_wdata", acc_wdata, 32'hBEEF_BEEF);
    txn("lw10", 0, 2, 0, 32'h10, 0, 3, 0, 32'hBEEF_1234, 5, 0, 32'hBEEF_1234);
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_se = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midrst_ctl", {26'd0, rdy[d], rv[d], re[d], en[d], we[d], 1'b0}, 32'h20);
      check("midrst_data", rdat[d] | wd[d] | {22'd0, strb[d], maddr[d]}, 32'd0);
    end
    @(negedge clk);
    rst_ = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rv[0] || rv[1]) hits++;
    end
    check("midrst_noresp", hits, 0);
    check("midrst_ready", {30'd0, rdy[0], rdy[1]}, 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
